iniciador_estimador: RTL
========================

INICIADOR_ESTIMADOR -- requirements
Module: iniciador_estimador

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles spent in any handshake wait state (legal 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sample_valid  input  1  new I/V sample present this cycle.
REQ-005 SHALL have ports sample_i, sample_v  input  32 each  raw current/voltage sample.
REQ-006 SHALL have port start_e  output  1  request to estimator.
REQ-007 SHALL have ports i_req, v_req  output  32 each  operands presented to estimator.
REQ-008 SHALL have port ack_e  input  1  estimator status: 1 = idle/done, 0 = busy.
REQ-009 SHALL have ports result_i, result_v  input  32 each  estimator results.
REQ-010 SHALL have ports est_i, est_v  output  32 each  captured results.
REQ-011 SHALL have port est_valid  output  1  one-cycle pulse, est_i/est_v updated.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have ports timeout_err, overrun_err  output  1 each  sticky error flags.
REQ-014 SHALL have port clr_err  input  1  synchronous clear of both sticky flags.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT_HI; all outputs registered.
REQ-016 In IDLE with sample_valid=1 and ack_e=1: latch sample_i/v into i_req/v_req, start_e<=1, enter REQ.
REQ-017 In IDLE with sample_valid=1 and ack_e=0: drop sample, set overrun_err, stay IDLE.
REQ-018 sample_valid in REQ or WAIT_HI SHALL be dropped and set overrun_err; i_req/v_req SHALL be stable outside IDLE.
REQ-019 In REQ: hold start_e=1 until ack_e sampled 0, then start_e<=0 and enter WAIT_HI.
REQ-020 In WAIT_HI: on ack_e sampled 1, est_i<=result_i, est_v<=result_v, est_valid<=1 for exactly one cycle, enter IDLE.
REQ-021 An 8-bit wait counter SHALL clear on entry to REQ and to WAIT_HI and increment each cycle spent there.
REQ-022 When the counter reaches TIMEOUT-1 without the awaited ack_e level: set timeout_err, start_e<=0, est_valid stays 0, est_i/est_v unchanged, enter IDLE.
REQ-023 With a one-cycle-latency estimator, est_valid SHALL be high 5 cycles after the sample_valid cycle; the next sample is accepted in that same cycle (throughput 1 per 5 cycles).
REQ-024 clr_err and a simultaneous error-setting event in the same cycle: set wins.
REQ-025 start_e SHALL never be high outside REQ; est_valid SHALL never be high in two consecutive cycles.

Reset
REQ-026 On reset: state IDLE, start_e=0, i_req=v_req=0, est_i=est_v=0, est_valid=0, busy=0, timeout_err=overrun_err=0, counter=0.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately with no est_valid pulse; the first sample after release restarts cleanly.

Structure
REQ-028 State encoding and default TIMEOUT SHALL live in the shared project package alongside the estimator interface width (32).
REQ-029 The wait counter with timeout compare SHALL be one sub-module, contador_timeout; everything else stays flat.

Verification
REQ-030 Paired with the existing pass-through estimator: sample_i=0x00000123, sample_v=0x00000456 -> est_valid pulse 5 cycles later, est_i=0x123, est_v=0x456, no flags.
REQ-031 Back-to-back samples every cycle for 20 cycles -> 4 est_valid pulses, overrun_err=1, each result matching its accepted sample.
REQ-032 ack_e tied 1 (estimator never responds) -> after 16 cycles in REQ, timeout_err=1, start_e=0, busy=0, est_i unchanged.
REQ-033 Estimator model holding ack_e=0 for 40 cycles -> timeout_err=1 after 16 cycles in WAIT_HI; clr_err next cycle -> flag 0.
REQ-034 Reset pulsed while in WAIT_HI -> all outputs at reset values, no est_valid; the following sample completes normally.

Source files
------------

// File: rtl/iniciador_estimador_pkg.sv
// Shared definitions for the estimator initiator: state encoding,
// default handshake timeout and estimator operand width.
`timescale 1ns/1ps
package iniciador_estimador_pkg;

    localparam int EST_W       = 32;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_HI = 2'd2
    } estado_t;

    function automatic logic is_wait(input estado_t s);
        return (s == ST_REQ) || (s == ST_WAIT_HI);
    endfunction

endpackage

// File: rtl/iniciador_estimador_contador.sv
// Wait counter for the handshake states; flags expiry once the
// count reaches TIMEOUT-1.
`timescale 1ns/1ps
module contador_timeout
    import iniciador_estimador_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iniciador_estimador.sv
// Hands raw I/V samples to an ack-based estimator and captures its
// results, with timeout and overrun detection.
`timescale 1ns/1ps
module iniciador_estimador
    import iniciador_estimador_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [EST_W-1:0] sample_i,
    input  logic [EST_W-1:0] sample_v,
    output logic             start_e,
    output logic [EST_W-1:0] i_req,
    output logic [EST_W-1:0] v_req,
    input  logic             ack_e,
    input  logic [EST_W-1:0] result_i,
    input  logic [EST_W-1:0] result_v,
    output logic [EST_W-1:0] est_i,
    output logic [EST_W-1:0] est_v,
    output logic             est_valid,
    output logic             busy,
    output logic             timeout_err,
    output logic             overrun_err,
    input  logic             clr_err
);

    estado_t          state_q, state_d;
    logic             start_e_q, start_e_d;
    logic [EST_W-1:0] i_req_q, i_req_d;
    logic [EST_W-1:0] v_req_q, v_req_d;
    logic [EST_W-1:0] est_i_q, est_i_d;
    logic [EST_W-1:0] est_v_q, est_v_d;
    logic             est_valid_q, est_valid_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic             overrun_err_q, overrun_err_d;

    logic             timeout_set;
    logic             overrun_set;
    logic             cnt_clr;
    logic             cnt_en;
    logic             expired;

    always_comb begin
        state_d     = state_q;
        start_e_d   = start_e_q;
        i_req_d     = i_req_q;
        v_req_d     = v_req_q;
        est_i_d     = est_i_q;
        est_v_d     = est_v_q;
        est_valid_d = 1'b0;
        timeout_set = 1'b0;
        overrun_set = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    if (ack_e) begin
                        i_req_d   = sample_i;
                        v_req_d   = sample_v;
                        start_e_d = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        overrun_set = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                overrun_set = sample_valid;
                if (!ack_e) begin
                    start_e_d = 1'b0;
                    state_d   = ST_WAIT_HI;
                end else if (expired) begin
                    timeout_set = 1'b1;
                    start_e_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                overrun_set = sample_valid;
                if (ack_e) begin
                    est_i_d     = result_i;
                    est_v_d     = result_v;
                    est_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (expired) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                start_e_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // A new error event outranks a same-cycle clear
        timeout_err_d = (timeout_err_q & ~clr_err) | timeout_set;
        overrun_err_d = (overrun_err_q & ~clr_err) | overrun_set;
    end

    assign cnt_clr = is_wait(state_d) && (state_d != state_q);
    assign cnt_en  = is_wait(state_q);

    contador_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_contador (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            start_e_q     <= 1'b0;
            i_req_q       <= '0;
            v_req_q       <= '0;
            est_i_q       <= '0;
            est_v_q       <= '0;
            est_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_e_q     <= start_e_d;
            i_req_q       <= i_req_d;
            v_req_q       <= v_req_d;
            est_i_q       <= est_i_d;
            est_v_q       <= est_v_d;
            est_valid_q   <= est_valid_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign start_e     = start_e_q;
    assign i_req       = i_req_q;
    assign v_req       = v_req_q;
    assign est_i       = est_i_q;
    assign est_v       = est_v_q;
    assign est_valid   = est_valid_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

endmodule
